// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: multi-stage valid/ready pipeline register with
// bubble collapsing, synchronous flush and an occupancy count.
module pipe_reg_hs #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned CW = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_d [STAGES];
  logic              tail_full;

  logic in_xfer;
  logic out_xfer;

  // A stage can advance when any stage at or past it
  // is empty, or the consumer takes the head beat.
  always_comb begin
    tail_full = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      tail_full = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        tail_full = tail_full & v[j];
      end
      rdy[i] = out_ready | ~tail_full;
    end
  end

  always_comb begin
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[STAGES-1] & ~flush;
  assign out_data  = d[STAGES-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            d[i] <= up_d[i];
          end
        end
      end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: directed and random checks of pipe_reg_hs
// for STAGES=1,2,4 against a beat-position queue model.
module tb_pipe_reg_hs;

  localparam int SZ [3] = '{1, 2, 4};
  localparam logic [7:0] RV [3] = '{8'h3C, 8'h00, 8'hA5};

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic reset = 1'b1;

  logic [2:0]      iv, ordy, fl;
  logic [2:0][7:0] id;
  logic [2:0]      ir_w, ov_w;
  logic [2:0][7:0] od_w;
  logic [0:0]      c1;
  logic [1:0]      c2;
  logic [2:0]      c4;
  logic [31:0]     cnt_w [3];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } beat_t;

  beat_t      q [3][$];
  logic [7:0] last_out [3];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  pipe_reg_hs #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h3C)) u1 (
    .clk(clk), .reset(reset), .flush(fl[0]),
    .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir_w[0]),
    .out_valid(ov_w[0]), .out_data(od_w[0]),
    .out_ready(ordy[0]), .count(c1)
  );

  pipe_reg_hs #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h00)) u2 (
    .clk(clk), .reset(reset), .flush(fl[1]),
    .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir_w[1]),
    .out_valid(ov_w[1]), .out_data(od_w[1]),
    .out_ready(ordy[1]), .count(c2)
  );

  pipe_reg_hs #(.WIDTH(8), .STAGES(4), .RESET_VAL(8'hA5)) u4 (
    .clk(clk), .reset(reset), .flush(fl[2]),
    .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir_w[2]),
    .out_valid(ov_w[2]), .out_data(od_w[2]),
    .out_ready(ordy[2]), .count(c4)
  );

  assign cnt_w[0] = 32'(c1);
  assign cnt_w[1] = 32'(c2);
  assign cnt_w[2] = 32'(c4);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beats carry their distance from the output; each edge a
  // beat moves one slot closer if that slot is (or becomes) free.
  task automatic model_step(input int k);
    logic  e_ir, e_ov;
    int    sz;
    beat_t b;
    string s;
    s = $sformatf("S%0d", SZ[k]);
    sz = q[k].size();
    e_ir = !fl[k] && (sz < SZ[k] || ordy[k]);
    e_ov = !fl[k] && sz > 0 && q[k][0].pos == 0;
    chk({s, " in_ready"}, 32'(ir_w[k]), 32'(e_ir));
    chk({s, " out_valid"}, 32'(ov_w[k]), 32'(e_ov));
    chk({s, " count"}, cnt_w[k], 32'(sz));
    chk({s, " out_data"}, 32'(od_w[k]), 32'(last_out[k]));
    if (fl[k]) begin
      q[k].delete();
    end else begin
      if (e_ov && ordy[k]) void'(q[k].pop_front());
      for (int j = 0; j < q[k].size(); j++) begin
        b = q[k][j];
        if (b.pos > 0) begin
          if (j == 0) begin
            b.pos = b.pos - 1;
          end else if (q[k][j-1].pos != b.pos - 1) begin
            b.pos = b.pos - 1;
          end
        end
        q[k][j] = b;
      end
      if (iv[k] && e_ir) begin
        b.d = id[k];
        b.pos = SZ[k] - 1;
        q[k].push_back(b);
      end
      if (q[k].size() > 0 && q[k][0].pos == 0)
        last_out[k] = q[k][0].d;
    end
  endtask

  task automatic apply_all(input logic v, input logic [7:0] d,
                           input logic r, input logic f);
    for (int k = 0; k < 3; k++) begin
      iv[k] = v;
      id[k] = d;
      ordy[k] = r;
      fl[k] = f;
    end
    #1;
    for (int k = 0; k < 3; k++) model_step(k);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      last_out[k] = RV[k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iv = '0; ordy = '0; fl = '0; id = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset out_valid", 32'(ov_w[k]), 32'd0);
      chk("reset count", cnt_w[k], 32'd0);
      chk("reset out_data", 32'(od_w[k]), 32'(RV[k]));
    end
    reset = 1'b0;
    tick();

    // streaming through an empty pipe
    apply_all(1, 8'h11, 1, 0); tick();
    apply_all(1, 8'h22, 1, 0); tick();
    apply_all(1, 8'h33, 1, 0);
    chk("stream first", 32'(od_w[1]), 32'h11);
    chk("stream cnt", cnt_w[1], 32'd2);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("stream second", 32'(od_w[1]), 32'h22);
    chk("stream cnt2", cnt_w[1], 32'd2);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("stream third", 32'(od_w[1]), 32'h33);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("stream empty", cnt_w[1], 32'd0);
    tick();

    // back-pressure
    apply_all(1, 8'hA1, 0, 0); tick();
    apply_all(1, 8'hA2, 0, 0); tick();
    apply_all(0, 8'h00, 0, 0);
    chk("bp count", cnt_w[1], 32'd2);
    chk("bp in_ready", 32'(ir_w[1]), 32'd0);
    chk("bp hold", 32'(od_w[1]), 32'hA1);
    tick();
    apply_all(1, 8'hA3, 1, 0);
    chk("bp accept", 32'(ir_w[1]), 32'd1);
    chk("bp head", 32'(od_w[1]), 32'hA1);
    tick();
    apply_all(0, 8'h00, 0, 0);
    chk("bp count kept", cnt_w[1], 32'd2);
    chk("bp next", 32'(od_w[1]), 32'hA2);
    tick();
    apply_all(0, 8'h00, 1, 0); tick();
    apply_all(0, 8'h00, 1, 0);
    chk("bp last", 32'(od_w[1]), 32'hA3);
    tick();
    apply_all(0, 8'h00, 1, 0); tick();

    // bubble collapse under stall
    apply_all(1, 8'h55, 0, 0); tick();
    apply_all(0, 8'h00, 0, 0); tick();
    apply_all(1, 8'h66, 0, 0); tick();
    apply_all(0, 8'h00, 0, 0);
    chk("bub count", cnt_w[1], 32'd2);
    chk("bub valid", 32'(ov_w[1]), 32'd1);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("bub first", 32'(od_w[1]), 32'h55);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("bub second", 32'(od_w[1]), 32'h66);
    chk("bub second v", 32'(ov_w[1]), 32'd1);
    tick();
    apply_all(0, 8'h00, 1, 0); tick();

    // flush with a beat offered in the flush cycle
    apply_all(1, 8'h88, 0, 0); tick();
    apply_all(1, 8'h99, 0, 0); tick();
    apply_all(1, 8'h77, 0, 1);
    chk("flush in_ready", 32'(ir_w[1]), 32'd0);
    chk("flush out_valid", 32'(ov_w[1]), 32'd0);
    tick();
    apply_all(0, 8'h00, 1, 0);
    chk("flush count", cnt_w[1], 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply_all(0, 8'h00, 1, 0);
      chk("post flush valid", 32'(ov_w[1]), 32'd0);
      chk("post flush data", 32'(od_w[1]), 32'h88);
      tick();
    end

    // asynchronous reset with the clock stopped
    apply_all(1, 8'hC1, 0, 0); tick();
    apply_all(1, 8'hC2, 0, 0); tick();
    iv = '0; fl = '0;
    clk_run = 1'b0;
    #7;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async out_valid", 32'(ov_w[k]), 32'd0);
      chk("async count", cnt_w[k], 32'd0);
      chk("async out_data", 32'(od_w[k]), 32'(RV[k]));
    end
    reset_model();
    #3;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk("release in_ready", 32'(ir_w[k]), 32'd1);
    clk_run = 1'b1;
    tick();

    // randomized traffic on all three depths
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k] = ($urandom_range(0, 9) < 6);
        id[k] = 8'($urandom);
        ordy[k] = ($urandom_range(0, 9) < 6);
        fl[k] = ($urandom_range(0, 39) == 0);
      end
      #1;
      for (int k = 0; k < 3; k++) model_step(k);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_hs.md
Name: pipe_reg_hs

Overview:
- Parametrised multi-stage pipeline register with a valid/ready handshake at both ends.
- Adds per-stage valid tracking, back-pressure with bubble collapsing, a synchronous flush and an occupancy count.
- Sits between datapath sections, for example fetch→decode or ALU→writeback, where a stage must stall or be squashed without losing or duplicating beats.

Parameters:
- WIDTH, 8: payload width in bits (≥1).
- STAGES, 2: number of register stages (≥1). STAGES=1 is a single handshaked register.
- RESET_VAL, 0: value loaded into every data register on reset (WIDTH bits).
- CW, $clog2(STAGES+1): width of the occupancy count. Derived; do not override.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight beats.
- in_valid  in  1  upstream beat present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  block can accept a beat this cycle.
- out_valid  out  1  stage STAGES-1 holds a beat.
- out_data  out  WIDTH  payload of stage STAGES-1.
- out_ready  in  1  downstream accepts this cycle.
- count  out  CW  number of valid stages, 0..STAGES.

Behaviour:
- Reset is asynchronous, active-high, and applied immediately regardless of clk.
  - All stage valid bits go to 0.
  - All data registers go to RESET_VAL.
  - count=0, out_valid=0, out_data=RESET_VAL.
  - in_ready=1 while reset is low and flush is low.
- Reset asserted mid-operation discards all beats. No partial transfer completes on the edge where reset is active.
- State per stage i (0 = input side): v[i] (1 bit) and d[i] (WIDTH bits).
- Stage readiness:
  - rdy[STAGES] = out_ready.
  - rdy[i] = ~v[i] | rdy[i+1].
- The ready path is combinational end to end, so bubbles collapse. Throughput is 1 beat/cycle when out_ready=1.
- Boundary handshakes:
  - in_ready = rdy[0] & ~flush.
  - out_valid = v[STAGES-1] & ~flush.
  - out_data = d[STAGES-1], registered with no combinational path from in_data.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Per-cycle update when flush=0, for each stage i:
  - If rdy[i] is set: v[i] <= v[i-1] (stage 0 uses in_valid).
  - d[i] loads the upstream data only when rdy[i] is set and the upstream valid is set. Otherwise d[i] holds, with no toggling on bubbles.
  - If rdy[i] is clear: v[i] and d[i] hold.
- Flush (flush=1 at an edge):
  - All v[i] <= 0. d[i] holds.
  - The in_ready and out_valid gating guarantees no beat is accepted or delivered in the flush cycle.
  - in_valid and in_data are ignored in that cycle.
- Latency: with out_ready=1 throughout, a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1. That is STAGES cycles from acceptance to output.
- Stall: if out_ready=0 with the pipe full, then in_ready=0 and out_data and out_valid stay stable until out_ready=1.
  - out_valid never deasserts without a transfer, except on flush or reset.
- Simultaneous input and output transfer when full: both occur in the same cycle and count is unchanged.
- count update:
  - count <= count + in_xfer - out_xfer.
  - On flush, count <= 0.
  - count is a register and must equal the popcount of v[] at every cycle. Saturation is never needed.
- Ordering: beats exit in acceptance order. No loss or duplication outside flush or reset.

Test Plan:
- Reset then idle. Assert reset mid-cycle with clk stopped. Required: out_valid=0, count=0, out_data=RESET_VAL (e.g. 8'h00) immediately, and in_ready=1 after release.
- Streaming, STAGES=2, out_ready=1. Drive 8'h11, 8'h22, 8'h33 on consecutive cycles. Required: out_data=11/22/33 on consecutive cycles, first appearing 2 cycles after acceptance, with count=2 steady.
- Back-pressure. Fill with A1, A2 while out_ready=0. Required: count=2, in_ready=0, out_data=A1 held. Raise out_ready for 1 cycle while in_valid=1 with A3. Required: A1 exits, A3 accepted, count stays 2.
- Bubble collapse. Accept 8'h55, idle 1 cycle, accept 8'h66, with out_ready=0. Required: both stages valid, count=2. Release out_ready: 55 then 66 on back-to-back cycles.
- Flush. With pipe full and in_valid=1 (8'h77) in the flush cycle. Required: in_ready=0 and out_valid=0 during flush. The next cycle has count=0, and 8'h77 never appears at the output.
- Randomised in_valid/out_ready, 1000 cycles, STAGES=1 and STAGES=4. Scoreboard check for order, no loss or duplication, and count equal to the number of valid stages every cycle.
